// File: rtl/axil_test_regs_pkg.sv
// Shared definitions for the AXI-Lite test register block: register word
// indices, AXI response codes, CTRL bit positions and a byte-strobe helper.
package axil_test_regs_pkg;

  // Word indices, i.e. byte offset [4:2]
  localparam logic [2:0] REG_ID        = 3'd0;
  localparam logic [2:0] REG_CTRL      = 3'd1;
  localparam logic [2:0] REG_SCRATCH0  = 3'd2;
  localparam logic [2:0] REG_SCRATCH1  = 3'd3;
  localparam logic [2:0] REG_CNT_LO    = 3'd4;
  localparam logic [2:0] REG_CNT_HI    = 3'd5;
  localparam logic [2:0] REG_WR_COUNT  = 3'd6;
  localparam logic [2:0] REG_ERR_COUNT = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_CNT_EN  = 0;
  localparam int CTRL_CNT_CLR = 1;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axil_test_cycle_counter.sv
// 64-bit free-running cycle counter with enable, synchronous clear and a
// high-word snapshot taken whenever the low word is read.
module axil_test_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] cnt_lo,
  output logic [31:0] hi_snap
);

  logic [63:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 64'd1;
  end

  // Snapshot pairs with the low word returned in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       hi_snap <= '0;
    else if (snap) hi_snap <= cnt[63:32];
  end

  assign cnt_lo = cnt[31:0];

endmodule

// File: rtl/axil_test_regs.sv
// AXI-Lite slave test register block (ID, CTRL, scratch, cycle counter, stats).
// Optional counter feature: define AXIL_TEST_REGS_COUNTER_EN to build it.
module axil_test_regs
  import axil_test_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h4E54_5031
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic [31:0]           scratch0, scratch1, wr_count, err_count;
  logic [31:0]           cnt_lo, hi_snap, ctrl_rd, rd_data;

  assign s_axi_awready = !aw_full;
  assign s_axi_wready  = !w_full;
  assign s_axi_arready = !s_axi_rvalid;

  // Write decode works on the held address so AW/W arrival order is irrelevant
  logic [2:0] wr_idx;
  logic       wr_commit, wr_legal, wr_ok, wr_err;
  assign wr_idx    = aw_addr[4:2];
  assign wr_commit = aw_full && w_full && !s_axi_bvalid;
  assign wr_legal  = ~|aw_addr[ADDR_WIDTH-1:5] &&
                     (wr_idx inside {REG_CTRL, REG_SCRATCH0, REG_SCRATCH1});
  assign wr_ok     = wr_commit && wr_legal;
  assign wr_err    = wr_commit && !wr_legal;

  logic [2:0] rd_idx;
  logic       rd_fire, rd_mapped, rd_err;
  assign rd_idx    = s_axi_araddr[4:2];
  assign rd_fire   = s_axi_arvalid && s_axi_arready;
  assign rd_mapped = ~|s_axi_araddr[ADDR_WIDTH-1:5];
  assign rd_err    = rd_fire && !rd_mapped;

  logic ctrl_wr;
  assign ctrl_wr = wr_ok && (wr_idx == REG_CTRL) && w_strb[0];

`ifdef AXIL_TEST_REGS_COUNTER_EN
  logic cnt_en;

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i)       cnt_en <= 1'b1;
    else if (ctrl_wr) cnt_en <= w_data[CTRL_CNT_EN];
  end

  axil_test_cycle_counter u_counter (
    .clk     (clk_i),
    .rst     (rstn_i),
    .en      (cnt_en),
    .clr     (ctrl_wr && w_data[CTRL_CNT_CLR]),
    .snap    (rd_fire && rd_mapped && (rd_idx == REG_CNT_LO)),
    .cnt_lo  (cnt_lo),
    .hi_snap (hi_snap)
  );

  assign ctrl_rd = {31'd0, cnt_en};
`else
  assign cnt_lo  = '0;
  assign hi_snap = '0;
  assign ctrl_rd = '0;
`endif

  // Holds fill on handshake and drain on commit; both cannot happen together
  // because a full hold deasserts its ready.
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end else if (wr_commit) begin
        aw_full <= 1'b0;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end else if (wr_commit) begin
        w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (wr_commit) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_bvalid && s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      scratch0  <= '0;
      scratch1  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (wr_ok && wr_idx == REG_SCRATCH0) scratch0 <= apply_strb(scratch0, w_data, w_strb);
      if (wr_ok && wr_idx == REG_SCRATCH1) scratch1 <= apply_strb(scratch1, w_data, w_strb);
      if (wr_ok) wr_count <= wr_count + 32'd1;
      // A write error and a read error can land in the same cycle
      err_count <= err_count + {31'd0, wr_err} + {31'd0, rd_err};
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    case (rd_idx)
      REG_ID:        rd_data = ID_VALUE;
      REG_CTRL:      rd_data = ctrl_rd;
      REG_SCRATCH0:  rd_data = scratch0;
      REG_SCRATCH1:  rd_data = scratch1;
      REG_CNT_LO:    rd_data = cnt_lo;
      REG_CNT_HI:    rd_data = hi_snap;
      REG_WR_COUNT:  rd_data = wr_count;
      REG_ERR_COUNT: rd_data = err_count;
      default:       rd_data = '0;
    endcase
    if (!rd_mapped) rd_data = '0;
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (rd_fire) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_data;
      s_axi_rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  logic unused;
  assign unused = ^{s_axi_awprot, s_axi_arprot, aw_addr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axil_test_regs.sv
// Scoreboard bench for axil_test_regs: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_axil_test_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [31:0] ID    = 32'h4E54_5031;
`ifdef AXIL_TEST_REGS_COUNTER_EN
  localparam logic [31:0] CTRL_RST = 32'h1;
`else
  localparam logic [31:0] CTRL_RST = 32'h0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    bit          chk_data;
  } r_exp_t;

  logic        clk_i, rstn_i;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [1:0]  b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] last_rdata;

  axil_test_regs dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [63:0] act,
                             input logic [63:0] lo, input logic [63:0] hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %h expected within %h..%h", name, act, lo, hi);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Monitor: handshakes complete at the next posedge, so compare at negedge
  always @(negedge clk_i) begin
    if (!rstn_i && s_axi_bvalid && s_axi_bready) begin
      if (b_q.size() == 0) timeout("b_unexpected");
      else check("bresp", {30'd0, s_axi_bresp}, {30'd0, b_q.pop_front()});
    end
    if (!rstn_i && s_axi_rvalid && s_axi_rready) begin
      if (r_q.size() == 0) timeout("r_unexpected");
      else begin
        r_exp_t e;
        e = r_q.pop_front();
        check("rresp", {30'd0, s_axi_rresp}, {30'd0, e.resp});
        if (e.chk_data) check("rdata", s_axi_rdata, e.data);
        last_rdata = s_axi_rdata;
      end
    end
  end

  task automatic drive_aw(input logic [31:0] addr, input int dly);
    int n;
    repeat (dly) begin @(posedge clk_i); #1; end
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    for (n = 0; n < 100 && !s_axi_awready; n++) begin @(posedge clk_i); #1; end
    if (!s_axi_awready) timeout("awready");
    @(posedge clk_i); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int n;
    repeat (dly) begin @(posedge clk_i); #1; end
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    for (n = 0; n < 100 && !s_axi_wready; n++) begin @(posedge clk_i); #1; end
    if (!s_axi_wready) timeout("wready");
    @(posedge clk_i); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    for (n = 0; n < 100 && !s_axi_bvalid; n++) begin @(posedge clk_i); #1; end
    if (!s_axi_bvalid) timeout("bvalid");
    else begin @(posedge clk_i); #1; end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [1:0] resp, input int aw_dly, input int w_dly,
                    input bit chk_lat, input bit push);
    if (push) b_q.push_back(resp);
    fork
      drive_aw(addr, aw_dly);
      drive_w(data, strb, w_dly);
    join
    if (chk_lat) begin
      check("b_early", {31'd0, s_axi_bvalid}, 32'd0);
      @(posedge clk_i); #1;
      check("b_latency", {31'd0, s_axi_bvalid}, 32'd1);
    end
    if (s_axi_bready) wait_b();
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                    input bit chk_data, input bit push);
    int n;
    if (push) r_q.push_back('{data: data, resp: resp, chk_data: chk_data});
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    for (n = 0; n < 100 && !s_axi_arready; n++) begin @(posedge clk_i); #1; end
    if (!s_axi_arready) timeout("arready");
    @(posedge clk_i); #1;
    s_axi_arvalid = 1'b0;
    if (s_axi_rready) begin
      for (n = 0; n < 100 && !s_axi_rvalid; n++) begin @(posedge clk_i); #1; end
      if (!s_axi_rvalid) timeout("rvalid");
      else begin @(posedge clk_i); #1; end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_awready"}, {31'd0, s_axi_awready}, 32'd1);
    check({tag, "_wready"},  {31'd0, s_axi_wready},  32'd1);
    check({tag, "_arready"}, {31'd0, s_axi_arready}, 32'd1);
    check({tag, "_bvalid"},  {31'd0, s_axi_bvalid},  32'd0);
    check({tag, "_rvalid"},  {31'd0, s_axi_rvalid},  32'd0);
    check({tag, "_bresp"},   {30'd0, s_axi_bresp},   32'd0);
    check({tag, "_rresp"},   {30'd0, s_axi_rresp},   32'd0);
    check({tag, "_rdata"},   s_axi_rdata,            32'd0);
  endtask

  initial begin
    logic [31:0] lo0, hi0, lo1, hi1;
    int n;
    rstn_i = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_idle("in_reset");
    rstn_i = 1'b0;
    @(posedge clk_i); #1;
    check_idle("post_reset");

    // Reset register contents
    rd(32'h00, ID,       OKAY, 1, 1);
    rd(32'h04, CTRL_RST, OKAY, 1, 1);
    rd(32'h18, 32'd0,    OKAY, 1, 1);
    rd(32'h1C, 32'd0,    OKAY, 1, 1);

    // Scratch with byte strobes; addr[1:0] ignored
    wr(32'h08, 32'hDEADBEEF, 4'hF, OKAY, 0, 0, 1, 1);
    wr(32'h08, 32'h000000AA, 4'h1, OKAY, 0, 0, 1, 1);
    rd(32'h08, 32'hDEADBEAA, OKAY, 1, 1);
    rd(32'h0B, 32'hDEADBEAA, OKAY, 1, 1);
    rd(32'h18, 32'd2,        OKAY, 1, 1);

    // Channel ordering: W first, AW first, simultaneous
    wr(32'h0C, 32'h11111111, 4'hF, OKAY, 3, 0, 1, 1);
    rd(32'h0C, 32'h11111111, OKAY, 1, 1);
    wr(32'h0C, 32'h22222222, 4'hF, OKAY, 0, 3, 1, 1);
    rd(32'h0C, 32'h22222222, OKAY, 1, 1);
    wr(32'h0C, 32'h33333333, 4'hF, OKAY, 0, 0, 1, 1);
    wr(32'h0C, 32'h55AA0000, 4'hC, OKAY, 0, 0, 1, 1);
    rd(32'h0C, 32'h55AA3333, OKAY, 1, 1);
    rd(32'h18, 32'd6,        OKAY, 1, 1);

    // Error responses
    wr(32'h00, 32'h12345678, 4'hF, SLVERR, 0, 0, 1, 1);
    rd(32'h00, ID,           OKAY,   1, 1);
    rd(32'h24, 32'd0,        SLVERR, 1, 1);
    rd(32'h1C, 32'd2,        OKAY,   1, 1);
    wr(32'h28, 32'hFFFFFFFF, 4'hF, SLVERR, 0, 0, 1, 1);
    rd(32'h08, 32'hDEADBEAA, OKAY, 1, 1);
    rd(32'h1C, 32'd3,        OKAY, 1, 1);
    rd(32'h18, 32'd6,        OKAY, 1, 1);

    // Back-pressure on B and R
    s_axi_bready = 1'b0;
    wr(32'h0C, 32'hA5A5A5A5, 4'hF, OKAY, 0, 0, 0, 1);
    wr(32'h0C, 32'h5A5A5A5A, 4'hF, OKAY, 0, 0, 0, 1);
    s_axi_rready = 1'b0;
    rd(32'h0C, 32'hA5A5A5A5, OKAY, 1, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check("bp_bvalid",  {31'd0, s_axi_bvalid},  32'd1);
      check("bp_bresp",   {30'd0, s_axi_bresp},   32'd0);
      check("bp_awready", {31'd0, s_axi_awready}, 32'd0);
      check("bp_wready",  {31'd0, s_axi_wready},  32'd0);
      check("bp_rvalid",  {31'd0, s_axi_rvalid},  32'd1);
      check("bp_rdata",   s_axi_rdata,            32'hA5A5A5A5);
    end
    s_axi_rready = 1'b1;
    @(posedge clk_i); #1;
    s_axi_bready = 1'b1;
    wait_b();
    wait_b();
    rd(32'h0C, 32'h5A5A5A5A, OKAY, 1, 1);
    rd(32'h18, 32'd8,        OKAY, 1, 1);

`ifdef AXIL_TEST_REGS_COUNTER_EN
    // Snapshot consistency across the low-word wrap
    force dut.u_counter.cnt = 64'h0000_0000_FFFF_FFFE;
    @(posedge clk_i); #1;
    release dut.u_counter.cnt;
    rd(32'h10, 32'd0, OKAY, 0, 1); lo0 = last_rdata;
    rd(32'h14, 32'd0, OKAY, 0, 1); hi0 = last_rdata;
    rd(32'h10, 32'd0, OKAY, 0, 1); lo1 = last_rdata;
    rd(32'h14, 32'd0, OKAY, 0, 1); hi1 = last_rdata;
    check_range("snap_pre_wrap",  {hi0, lo0}, 64'h0_FFFF_FFFE, 64'h1_0000_0010);
    check_range("snap_post_wrap", {hi1, lo1}, 64'h1_0000_0000, 64'h1_0000_0020);
    // Clear (and stop), then verify frozen
    wr(32'h04, 32'h2, 4'hF, OKAY, 0, 0, 1, 1);
    rd(32'h04, 32'h0, OKAY, 1, 1);
    rd(32'h10, 32'd0, OKAY, 0, 1); lo0 = last_rdata;
    check_range("cnt_after_clr", {32'd0, lo0}, 64'd0, 64'd9);
    wr(32'h04, 32'h0, 4'hF, OKAY, 0, 0, 1, 1);
    rd(32'h10, 32'd0, OKAY, 0, 1); lo0 = last_rdata;
    repeat (3) @(posedge clk_i);
    #1;
    rd(32'h10, 32'd0, OKAY, 0, 1); lo1 = last_rdata;
    check("cnt_frozen", lo1, lo0);
`else
    // Counter absent: CTRL and counter words read 0, CTRL write still OKAY
    wr(32'h04, 32'h3, 4'hF, OKAY, 0, 0, 1, 1);
    rd(32'h04, 32'h0, OKAY, 1, 1);
    rd(32'h10, 32'h0, OKAY, 1, 1);
    rd(32'h14, 32'h0, OKAY, 1, 1);
    rd(32'h18, 32'd9, OKAY, 1, 1);
`endif

    // Reset with both responses pending
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    wr(32'h08, 32'h12345678, 4'hF, OKAY, 0, 0, 0, 0);
    rd(32'h08, 32'h0, OKAY, 0, 0);
    for (n = 0; n < 100 && !(s_axi_bvalid && s_axi_rvalid); n++) begin @(posedge clk_i); #1; end
    if (!(s_axi_bvalid && s_axi_rvalid)) timeout("pre_reset_pending");
    #3;
    rstn_i = 1'b1;
    #1;
    check_idle("async_reset");
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    @(posedge clk_i); #1;
    rd(32'h08, 32'h0,    OKAY, 1, 1);
    rd(32'h18, 32'd0,    OKAY, 1, 1);
    rd(32'h04, CTRL_RST, OKAY, 1, 1);

    for (n = 0; n < 50 && (b_q.size() != 0 || r_q.size() != 0); n++) @(posedge clk_i);
    check("b_queue_drained", b_q.size(), 32'd0);
    check("r_queue_drained", r_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axil_test_regs.md
# axil_test_regs

AXI-Lite slave test device on the CPU's AXI-Lite bus, directly downstream of `wb_axil_bridge`; it consumes the bridge's `m_axi_*` channels. It provides an ID word, a control register, two scratch registers, a snapshot-safe 64-bit cycle counter and write/error statistics. Firmware uses it to prove the Wishbone-to-AXI path end to end, including byte strobes, error responses and back-pressure.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `s_axi_awaddr`/`s_axi_araddr`.
- `ID_VALUE`, 32'h4E54_5031: constant returned by the ID register.

Ports:
- `clk_i`  in  1  clock, the same domain as the bridge (`axi_aclk`).
- `rstn_i`  in  1  reset: asynchronous, **active-high** despite the name. This matches `wb_axil_bridge`, which also receives `!cpu_resetn` on `rstn_i`.
- `s_axi_awaddr` in ADDR_WIDTH, `s_axi_awprot` in 3 (ignored), `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in ADDR_WIDTH, `s_axi_arprot` in 3 (ignored), `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.

## Operation
- **Decode.** Only `addr[4:2]` selects the register; `addr[1:0]` is ignored. Any address ≥ 0x20 is unmapped.
- **Register map:**
  - 0x00 ID: read-only, returns `ID_VALUE`.
  - 0x04 CTRL: read/write. bit0 CNT_EN (reset 1). bit1 CNT_CLR: writing 1 zeroes the counter; the bit always reads 0. Other bits read 0.
  - 0x08 SCRATCH0 and 0x0C SCRATCH1: read/write, reset 0, honour `wstrb` per byte.
  - 0x10 CNT_LO: read-only. Returns `cnt[31:0]` and, in the same cycle, latches `cnt[63:32]` into HI_SNAP.
  - 0x14 CNT_HI: read-only, returns HI_SNAP.
  - 0x18 WR_COUNT: read-only, 32-bit count of accepted writes with OKAY response; wraps.
  - 0x1C ERR_COUNT: read-only, 32-bit count of SLVERR responses on both channels; wraps.
- **Errors.** A write to a read-only or unmapped register gets `bresp`=SLVERR (2'b10) with no side effect. A read of an unmapped register gets `rresp`=SLVERR with `rdata`=0. Every other access gets OKAY (2'b00).
- **Write path.** AW and W are captured independently into holding registers, in either order or in the same cycle. The write commits in the cycle both holds are full and `bvalid` is 0.
- **Cycle counter.** 64 bits, increments every cycle while CNT_EN=1, wraps to 0. A CNT_CLR write takes priority over the increment.
- **Same-cycle events.** A read commit and a write commit in the same cycle are independent. A read of a register being written in that cycle returns the old value. A write to CTRL takes effect from the next cycle.

## Timing
- **Reset values:** `awready`=`wready`=`arready`=1; `bvalid`=`rvalid`=0; `bresp`=`rresp`=0; `rdata`=0; all counters and HI_SNAP = 0.
- **Ready signals:**
  - `awready` = AW hold empty.
  - `wready` = W hold empty.
  - `arready` = !`rvalid`.
  - At most one write and one read are outstanding.
- **Write latency.** `bvalid` rises one cycle after the cycle in which both holds are full. Both holds empty in that same cycle, so `awready`/`wready` return one cycle after the commit. `bvalid`/`bresp` hold until `bready`.
- **Write back-pressure.** A new AW/W pair may be captured while `bvalid`=1, but it commits only after the B handshake completes.
- **Read latency.** `rvalid` rises one cycle after the AR handshake. `rdata`/`rresp` are registered and stable until `rready`.
- **Read throughput.** Back-to-back reads run at one per 2 cycles.
- **Reset mid-transaction.** Holds and pending responses are discarded and all outputs return to their reset values immediately.

## Configuration
- Macro: `AXIL_TEST_REGS_COUNTER_EN`.
- **Defined:** the 64-bit counter, HI_SNAP, CNT_EN and CNT_CLR behave as above.
- **Undefined:**
  - No counter logic is built.
  - CNT_LO and CNT_HI read 0 with OKAY.
  - CTRL bits 0 and 1 read 0; writes to CTRL still return OKAY.

## Structure
- **Package `axil_test_regs_pkg`:**
  - Register offset localparams (`REG_ID` .. `REG_ERR_COUNT`).
  - AXI response codes `RESP_OKAY`/`RESP_SLVERR`.
  - CTRL bit indices.
- **Sub-module `axil_test_cycle_counter`:** the 64-bit counter with enable, clear and HI snapshot, instantiated only under the macro.

## Test plan
- **Scratch write/read:** write 0xDEADBEEF to 0x08 with `wstrb`=4'hF, then write 0x000000AA with `wstrb`=4'h1. Reading 0x08 → 0xDEADBEAA, OKAY; WR_COUNT=2.
- **Channel ordering:** W presented 3 cycles before AW, then the same write with AW first, then AW and W in the same cycle. Each → one `bvalid` exactly one cycle after the later capture, `bresp`=OKAY.
- **Error responses:** write to 0x00 → SLVERR, ID unchanged. Read 0x24 → SLVERR, `rdata`=0. ERR_COUNT=2.
- **Back-pressure:** hold `bready`=0 for 10 cycles with a second AW/W pair pending. The second write must not commit, and `bvalid` stays high with a stable `bresp`. `rready`=0 holds `rdata`.
- **Counter:**
  - Preload the counter to 0xFFFF_FFFE via force, then read CNT_LO and CNT_HI → a consistent 64-bit snapshot across the low-word wrap.
  - Write CTRL=0x2 → the next CNT_LO read is small (< 10).
  - Write CTRL=0 → two reads return equal values.
- **Reset:** assert `rstn_i` while `bvalid`=1 and `rvalid`=1 → both drop asynchronously, the readies go to 1, SCRATCH0 reads 0 after release.
